dram_bank_cmd_gen: RTL

- Sits directly downstream of the DRAM address translator.
- Takes one decoded request at a time (bank/row/col plus read/write) and tracks the open row of every bank.
- Emits the DRAM command sequence (PRE, ACT, RD/WR) with tRP/tRCD/tCL spacing, then pulses done with a hit/miss/conflict status.

---
 rtl/dram_bank_cmd_gen.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/dram_bank_cmd_gen.sv
// Per-bank open-row tracker and DRAM command sequencer (PRE/ACT/RD/WR) for one request at a time.
// Latency from handshake: hit 2+T_CL, miss 2+T_RCD+T_CL, conflict 2+T_RP+T_RCD+T_CL cycles to done.
// Backpressure: req_ready is high only while idle; req_valid seen while not ready is ignored.
module dram_bank_cmd_gen #(
   parameter int NUM_OF_BANKS = 8,
   parameter int NUM_OF_ROWS  = 128,
   parameter int NUM_OF_COLS  = 8,
   parameter int T_RP         = 3,
   parameter int T_RCD        = 3,
   parameter int T_CL         = 2,
   localparam int BW = $clog2(NUM_OF_BANKS),
   localparam int RW = $clog2(NUM_OF_ROWS),
   localparam int CW = $clog2(NUM_OF_COLS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [BW-1:0] req_bank_id,
   input  logic [RW-1:0] req_row_id,
   input  logic [CW-1:0] req_col_id,
   output logic          cmd_valid,
   output logic [2:0]    cmd_op,
   output logic [BW-1:0] cmd_bank,
   output logic [RW-1:0] cmd_row,
   output logic [CW-1:0] cmd_col,
   output logic          done,
   output logic [1:0]    resp_status
);

   typedef enum logic [3:0] {
      S_IDLE, S_DECIDE, S_PRE, S_WAIT_RP, S_ACT,
      S_WAIT_RCD, S_ACCESS, S_WAIT_CL, S_DONE
   } state_t;

   localparam logic [2:0] OP_ACT = 3'd1;
   localparam logic [2:0] OP_RD  = 3'd2;
   localparam logic [2:0] OP_WR  = 3'd3;
   localparam logic [2:0] OP_PRE = 3'd4;

   localparam logic [1:0] ST_HIT  = 2'd0;
   localparam logic [1:0] ST_MISS = 2'd1;
   localparam logic [1:0] ST_CONF = 2'd2;

   // Wait-state load values; a load of zero means the wait state is skipped.
   localparam logic [3:0] RP_LD  = 4'(T_RP - 1);
   localparam logic [3:0] RCD_LD = 4'(T_RCD - 1);
   localparam logic [3:0] CL_LD  = 4'(T_CL - 1);

   state_t                         state_q, state_d;
   logic [3:0]                     cnt_q, cnt_d;
   logic                           wr_q, wr_d;
   logic [BW-1:0]                  bank_q, bank_d;
   logic [RW-1:0]                  row_q, row_d;
   logic [CW-1:0]                  col_q, col_d;
   logic [1:0]                     status_q, status_d;
   logic [NUM_OF_BANKS-1:0]        bank_open_q, bank_open_d;
   logic [NUM_OF_BANKS-1:0][RW-1:0] open_row_q, open_row_d;

   logic                           req_ready_q, req_ready_d;
   logic                           cmd_valid_q, cmd_valid_d;
   logic [2:0]                     cmd_op_q, cmd_op_d;
   logic [BW-1:0]                  cmd_bank_q, cmd_bank_d;
   logic [RW-1:0]                  cmd_row_q, cmd_row_d;
   logic [CW-1:0]                  cmd_col_q, cmd_col_d;
   logic                           done_q, done_d;
   logic [1:0]                     resp_status_q, resp_status_d;

   // Next state, then the registered outputs and bank-table update of the state being entered.
   // PRE/ACT/ACCESS/DONE/IDLE-entry each last one cycle, so decoding on state_d gives exactly one pulse.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      wr_d          = wr_q;
      bank_d        = bank_q;
      row_d         = row_q;
      col_d         = col_q;
      status_d      = status_q;
      bank_open_d   = bank_open_q;
      open_row_d    = open_row_q;
      req_ready_d   = 1'b0;
      cmd_valid_d   = 1'b0;
      cmd_op_d      = 3'd0;
      cmd_bank_d    = '0;
      cmd_row_d     = '0;
      cmd_col_d     = '0;
      done_d        = 1'b0;
      resp_status_d = 2'd0;

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               wr_d    = req_write;
               bank_d  = req_bank_id;
               row_d   = req_row_id;
               col_d   = req_col_id;
               state_d = S_DECIDE;
            end
         end
         S_DECIDE: begin
            if (!bank_open_q[bank_q]) begin
               status_d = ST_MISS;
               state_d  = S_ACT;
            end else if (open_row_q[bank_q] == row_q) begin
               status_d = ST_HIT;
               state_d  = S_ACCESS;
            end else begin
               status_d = ST_CONF;
               state_d  = S_PRE;
            end
         end
         S_PRE: begin
            if (RP_LD == 4'd0) begin
               state_d = S_ACT;
            end else begin
               cnt_d   = RP_LD;
               state_d = S_WAIT_RP;
            end
         end
         S_WAIT_RP: begin
            if (cnt_q == 4'd1) state_d = S_ACT;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_ACT: begin
            if (RCD_LD == 4'd0) begin
               state_d = S_ACCESS;
            end else begin
               cnt_d   = RCD_LD;
               state_d = S_WAIT_RCD;
            end
         end
         S_WAIT_RCD: begin
            if (cnt_q == 4'd1) state_d = S_ACCESS;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_ACCESS: begin
            if (CL_LD == 4'd0) begin
               state_d = S_DONE;
            end else begin
               cnt_d   = CL_LD;
               state_d = S_WAIT_CL;
            end
         end
         S_WAIT_CL: begin
            if (cnt_q == 4'd1) state_d = S_DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      case (state_d)
         S_IDLE: req_ready_d = 1'b1;
         S_PRE: begin
            cmd_valid_d         = 1'b1;
            cmd_op_d            = OP_PRE;
            cmd_bank_d          = bank_q;
            bank_open_d[bank_q] = 1'b0;
         end
         S_ACT: begin
            cmd_valid_d         = 1'b1;
            cmd_op_d            = OP_ACT;
            cmd_bank_d          = bank_q;
            cmd_row_d           = row_q;
            bank_open_d[bank_q] = 1'b1;
            open_row_d[bank_q]  = row_q;
         end
         S_ACCESS: begin
            cmd_valid_d = 1'b1;
            cmd_op_d    = wr_q ? OP_WR : OP_RD;
            cmd_bank_d  = bank_q;
            cmd_col_d   = col_q;
         end
         S_DONE: begin
            done_d        = 1'b1;
            resp_status_d = status_q;
         end
         default: ;
      endcase
   end

   // State, request latch, bank table and registered outputs; reset aborts any sequence in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= 4'd0;
         wr_q          <= 1'b0;
         bank_q        <= '0;
         row_q         <= '0;
         col_q         <= '0;
         status_q      <= 2'd0;
         bank_open_q   <= '0;
         open_row_q    <= '0;
         req_ready_q   <= 1'b1;
         cmd_valid_q   <= 1'b0;
         cmd_op_q      <= 3'd0;
         cmd_bank_q    <= '0;
         cmd_row_q     <= '0;
         cmd_col_q     <= '0;
         done_q        <= 1'b0;
         resp_status_q <= 2'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wr_q          <= wr_d;
         bank_q        <= bank_d;
         row_q         <= row_d;
         col_q         <= col_d;
         status_q      <= status_d;
         bank_open_q   <= bank_open_d;
         open_row_q    <= open_row_d;
         req_ready_q   <= req_ready_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_op_q      <= cmd_op_d;
         cmd_bank_q    <= cmd_bank_d;
         cmd_row_q     <= cmd_row_d;
         cmd_col_q     <= cmd_col_d;
         done_q        <= done_d;
         resp_status_q <= resp_status_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign cmd_valid   = cmd_valid_q;
   assign cmd_op      = cmd_op_q;
   assign cmd_bank    = cmd_bank_q;
   assign cmd_row     = cmd_row_q;
   assign cmd_col     = cmd_col_q;
   assign done        = done_q;
   assign resp_status = resp_status_q;

endmodule
